alu_arbiter: RTL

- Sequences the shared 16-bit ALU and shares it between two requesters: r0 (core execute path) and r1 (auxiliary/debug engine).
- Registers operands, drives the ALU for one cycle, and captures the result and flags.
- Returns the result through a done/ack handshake.
- Owns the architectural flag register (N,V,Z) and feeds it back to the ALU as the incoming flags.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/rr_arb2.sv | 26 ++
 rtl/alu_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Holds the default widths, the opcode constants understood by the shared
// ALU, the flag bit positions and the arbiter FSM state encoding.
package alu_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_OP_W   = 3;
  localparam int DEF_FLAG_W = 3;

  // Opcodes are interpreted by the ALU only; the arbiter forwards them untouched.
  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_RED    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRL    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  localparam int FLAG_N = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   req  - request vector, bit X for requester X
//   last - index of the requester granted most recently
//   en   - arbitration enable; no grant is issued while low
//   gnt  - one-hot (or zero) grant vector
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  // Grant decision: a tie goes to the requester that did not win last time.
  always_comb begin
    gnt = 2'b00;
    if (!en) begin
      gnt = 2'b00;
    end else if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Sequencer that shares one external 16-bit ALU between two requesters
// (r0: core execute path, r1: auxiliary/debug engine). An operation is
// granted in IDLE, driven to the ALU for one EXEC cycle, and its result held
// in RESP until the owning requester acknowledges it. The block also owns
// the architectural N/V/Z flag register and feeds it back to the ALU.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   rX_req/in1/in2/op/flag_we  - request and operands from requester X
//   rX_gnt                     - combinational grant, operands latched on this edge
//   rX_done / rX_ack           - result-valid / result-consumed handshake
//   result, flags, busy        - shared result, flag register, not-IDLE indicator
//   alu_in1/in2/op/flag_in     - operands driven to the ALU
//   alu_out, alu_flag          - ALU result and flags
module alu_arbiter #(
  parameter int DATA_W = alu_pkg::DEF_DATA_W,
  parameter int OP_W   = alu_pkg::DEF_OP_W,
  parameter int FLAG_W = alu_pkg::DEF_FLAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic [DATA_W-1:0] r0_in1,
  input  logic [DATA_W-1:0] r0_in2,
  input  logic [OP_W-1:0]   r0_op,
  input  logic              r0_flag_we,
  output logic              r0_gnt,
  output logic              r0_done,
  input  logic              r0_ack,
  input  logic              r1_req,
  input  logic [DATA_W-1:0] r1_in1,
  input  logic [DATA_W-1:0] r1_in2,
  input  logic [OP_W-1:0]   r1_op,
  input  logic              r1_flag_we,
  output logic              r1_gnt,
  output logic              r1_done,
  input  logic              r1_ack,
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] flags,
  output logic              busy,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_op,
  output logic [FLAG_W-1:0] alu_flag_in,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flag
);

  import alu_pkg::*;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] in1_q, in1_d;
  logic [DATA_W-1:0] in2_q, in2_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              busy_q;
  logic [1:0]        done_q;
  logic [1:0]        gnt_s;
  logic              arb_en_s;
  logic              owner_ack_s;

  // Gating with rst_n keeps both grants low while reset is held, even though
  // the state register already reads IDLE.
  assign arb_en_s = rst_n & (state_q == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .req  ({r1_req, r0_req}),
    .last (last_q),
    .en   (arb_en_s),
    .gnt  (gnt_s)
  );

  assign r0_gnt      = gnt_s[0];
  assign r1_gnt      = gnt_s[1];
  assign owner_ack_s = owner_q ? r1_ack : r0_ack;

  assign r0_done     = done_q[0];
  assign r1_done     = done_q[1];
  assign busy        = busy_q;
  assign result      = result_q;
  assign flags       = flags_q;
  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;
  assign alu_op      = op_q;
  assign alu_flag_in = flags_q;

  // Next-state and datapath-load logic for the IDLE/EXEC/RESP sequencer.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_s[0]) begin
          in1_d   = r0_in1;
          in2_d   = r0_in2;
          op_d    = r0_op;
          we_d    = r0_flag_we;
          owner_d = 1'b0;
          last_d  = 1'b0;
          state_d = ST_EXEC;
        end else if (gnt_s[1]) begin
          in1_d   = r1_in1;
          in2_d   = r1_in2;
          op_d    = r1_op;
          we_d    = r1_flag_we;
          owner_d = 1'b1;
          last_d  = 1'b1;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        result_d = alu_out;
        if (we_q) begin
          flags_d = alu_flag;
        end else begin
          flags_d = flags_q;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's ack releases the result; the other ack is ignored.
        if (owner_ack_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand, result and flag registers; done/busy registered from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      in1_q    <= {DATA_W{1'b0}};
      in2_q    <= {DATA_W{1'b0}};
      op_q     <= {OP_W{1'b0}};
      result_q <= {DATA_W{1'b0}};
      flags_q  <= {FLAG_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      busy_q   <= (state_d != ST_IDLE);
      if (state_d == ST_RESP) begin
        done_q <= owner_d ? 2'b10 : 2'b01;
      end else begin
        done_q <= 2'b00;
      end
    end
  end

endmodule
